// File: rtl/ascon_ctrl_fsm.sv
// Sequencer for the Ascon-128 permutation_xor datapath: init p12, AD p6, PT p6, final p12.
// Optional abort input enabled by defining ASCON_CTRL_ABORT_EN.
module ascon_ctrl_fsm #(
   parameter int unsigned ROUNDS_A = 12,
   parameter int unsigned ROUNDS_B = 6,
   parameter int unsigned BLK_W    = 8
) (
   input  logic             clock_i,
   input  logic             resetb_i,
   input  logic             start_i,
   input  logic [BLK_W-1:0] nb_ad_i,
   input  logic [BLK_W-1:0] nb_pt_i,
   input  logic             blk_valid_i,
   output logic             blk_ready_o,
`ifdef ASCON_CTRL_ABORT_EN
   input  logic             abort_i,
`endif
   output logic             select_o,
   output logic [3:0]       round_o,
   output logic             ena_xor_up_o,
   output logic             ena_xor_down_o,
   output logic [2:0]       xor_down_sel_o,
   output logic             ena_reg_state_o,
   output logic             cipher_valid_o,
   output logic             tag_valid_o,
   output logic             busy_o
);

   typedef enum logic [2:0] {
      StIdle, StInit, StWaitAd, StPermAd, StWaitPt, StPermPt, StFinal, StDone
   } state_e;

   localparam logic [3:0] RndA0 = 4'(12 - ROUNDS_A);
   localparam logic [3:0] RndB0 = 4'(12 - ROUNDS_B);
   localparam logic [BLK_W-1:0] One = BLK_W'(1);

   state_e           state_q;
   logic [BLK_W-1:0] ad_cnt_q, pt_cnt_q;
   logic [3:0]       round_q;
   logic [2:0]       sel_q;
   logic             select_q, ready_q, xor_down_q, ena_reg_q, tag_q;
   logic             abort, xfer;

`ifdef ASCON_CTRL_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   // Transfer cycle is the first permutation round, so it bypasses the output registers.
   assign xfer            = ready_q & blk_valid_i & ~abort;
   assign blk_ready_o     = ready_q;
   assign select_o        = select_q;
   assign round_o         = round_q;
   assign ena_xor_up_o    = xfer;
   assign ena_xor_down_o  = xor_down_q;
   assign xor_down_sel_o  = sel_q;
   assign ena_reg_state_o = ena_reg_q | xfer;
   assign cipher_valid_o  = xfer & (state_q == StWaitPt);
   assign tag_valid_o     = tag_q;
   assign busy_o          = (state_q != StIdle);

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q    <= StIdle;
         ad_cnt_q   <= '0;
         pt_cnt_q   <= '0;
         round_q    <= '0;
         sel_q      <= '0;
         select_q   <= 1'b0;
         ready_q    <= 1'b0;
         xor_down_q <= 1'b0;
         ena_reg_q  <= 1'b0;
         tag_q      <= 1'b0;
      end else begin
         round_q    <= '0;
         sel_q      <= '0;
         select_q   <= 1'b0;
         ready_q    <= 1'b0;
         xor_down_q <= 1'b0;
         ena_reg_q  <= 1'b0;
         tag_q      <= 1'b0;
         if (abort) begin
            state_q  <= StIdle;
            ad_cnt_q <= '0;
            pt_cnt_q <= '0;
         end else begin
            case (state_q)
               StIdle: if (start_i) begin
                  state_q   <= StInit;
                  ad_cnt_q  <= (nb_ad_i == '0) ? One : nb_ad_i;
                  pt_cnt_q  <= (nb_pt_i == '0) ? One : nb_pt_i;
                  select_q  <= 1'b1;
                  ena_reg_q <= 1'b1;
                  round_q   <= RndA0;
               end
               StInit: if (round_q == 4'd11) begin
                  state_q <= StWaitAd;
                  ready_q <= 1'b1;
                  round_q <= RndB0;
               end else begin
                  round_q   <= round_q + 4'd1;
                  ena_reg_q <= 1'b1;
                  if (round_q == 4'd10) begin
                     xor_down_q <= 1'b1;
                     sel_q      <= 3'd1;
                  end
               end
               StWaitAd: if (xfer) begin
                  state_q   <= StPermAd;
                  ad_cnt_q  <= ad_cnt_q - One;
                  round_q   <= RndB0 + 4'd1;
                  ena_reg_q <= 1'b1;
               end else begin
                  ready_q <= 1'b1;
                  round_q <= RndB0;
               end
               StPermAd: if (round_q == 4'd11) begin
                  ready_q <= 1'b1;
                  if (ad_cnt_q == '0) begin
                     state_q <= StWaitPt;
                     round_q <= (pt_cnt_q == One) ? RndA0 : RndB0;
                  end else begin
                     state_q <= StWaitAd;
                     round_q <= RndB0;
                  end
               end else begin
                  round_q   <= round_q + 4'd1;
                  ena_reg_q <= 1'b1;
                  if (round_q == 4'd10 && ad_cnt_q == '0) begin
                     xor_down_q <= 1'b1;
                     sel_q      <= (pt_cnt_q == One) ? 3'd4 : 3'd2;
                  end
               end
               StWaitPt: if (xfer) begin
                  ena_reg_q <= 1'b1;
                  pt_cnt_q  <= pt_cnt_q - One;
                  if (pt_cnt_q == One) begin
                     state_q <= StFinal;
                     round_q <= RndA0 + 4'd1;
                  end else begin
                     state_q <= StPermPt;
                     round_q <= RndB0 + 4'd1;
                  end
               end else begin
                  ready_q <= 1'b1;
                  round_q <= (pt_cnt_q == One) ? RndA0 : RndB0;
               end
               StPermPt: if (round_q == 4'd11) begin
                  state_q <= StWaitPt;
                  ready_q <= 1'b1;
                  round_q <= (pt_cnt_q == One) ? RndA0 : RndB0;
               end else begin
                  round_q   <= round_q + 4'd1;
                  ena_reg_q <= 1'b1;
                  if (round_q == 4'd10 && pt_cnt_q == One) begin
                     xor_down_q <= 1'b1;
                     sel_q      <= 3'd3;
                  end
               end
               StFinal: if (round_q == 4'd11) begin
                  state_q <= StDone;
                  tag_q   <= 1'b1;
               end else begin
                  round_q   <= round_q + 4'd1;
                  ena_reg_q <= 1'b1;
                  if (round_q == 4'd10) begin
                     xor_down_q <= 1'b1;
                     sel_q      <= 3'd1;
                  end
               end
               StDone:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: cycle-exact event checks against hand-derived timelines.
// Abort checks are compiled only with ASCON_CTRL_ABORT_EN.
module tb_ascon_ctrl_fsm;

   logic       clock_i = 1'b0;
   logic       resetb_i = 1'b0;
   logic       start_i = 1'b0;
   logic [7:0] nb_ad_i = '0;
   logic [7:0] nb_pt_i = '0;
   logic       blk_valid_i = 1'b0;
   logic       blk_ready_o, select_o, ena_xor_up_o, ena_xor_down_o, ena_reg_state_o;
   logic       cipher_valid_o, tag_valid_o, busy_o;
   logic [3:0] round_o;
   logic [2:0] xor_down_sel_o;
`ifdef ASCON_CTRL_ABORT_EN
   logic       abort_i = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   // Per-run event log
   int n_select, select_cyc, rnd_err, n_xfer, n_cipher, cipher_cyc, cipher_rnd;
   int n_sel1, n_sel2, n_sel3, n_sel4, sel1_cyc, sel4_cyc, sel3_cipher, tag_cyc;
   int first_ready, up_err;
   int xfer_cyc [8];
   int xfer_rnd [8];

   ascon_ctrl_fsm dut (
      .clock_i        (clock_i),
      .resetb_i       (resetb_i),
      .start_i        (start_i),
      .nb_ad_i        (nb_ad_i),
      .nb_pt_i        (nb_pt_i),
      .blk_valid_i    (blk_valid_i),
      .blk_ready_o    (blk_ready_o),
`ifdef ASCON_CTRL_ABORT_EN
      .abort_i        (abort_i),
`endif
      .select_o       (select_o),
      .round_o        (round_o),
      .ena_xor_up_o   (ena_xor_up_o),
      .ena_xor_down_o (ena_xor_down_o),
      .xor_down_sel_o (xor_down_sel_o),
      .ena_reg_state_o(ena_reg_state_o),
      .cipher_valid_o (cipher_valid_o),
      .tag_valid_o    (tag_valid_o),
      .busy_o         (busy_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Cycle 0 presents start; d<0 holds blk_valid_i high, else valid after d ready cycles.
   task automatic run_enc(input logic [7:0] nad, input logic [7:0] npt, input int d,
                          input int glitch_a, input int glitch_b);
      int  wait_cnt = 0;
      bit  done = 0;
      n_select = 0; select_cyc = -1; rnd_err = 0; n_xfer = 0; n_cipher = 0;
      cipher_cyc = -1; cipher_rnd = -1; n_sel1 = 0; n_sel2 = 0; n_sel3 = 0; n_sel4 = 0;
      sel1_cyc = -1; sel4_cyc = -1; sel3_cipher = -1; tag_cyc = -1; first_ready = -1;
      up_err = 0;
      @(negedge clock_i);
      nb_ad_i = nad; nb_pt_i = npt; start_i = 1'b1; blk_valid_i = (d < 0);
      for (int c = 1; c < 400 && !done; c++) begin
         @(negedge clock_i);
         start_i = (c == glitch_a || c == glitch_b);
         if (d < 0) blk_valid_i = 1'b1;
         else if (blk_ready_o) begin
            blk_valid_i = (wait_cnt >= d);
            wait_cnt++;
         end else blk_valid_i = 1'b0;
         #1;
         if (select_o) begin n_select++; select_cyc = c; end
         if (c <= 12 && round_o != 4'(c - 1)) rnd_err++;
         if (blk_ready_o && first_ready < 0) first_ready = c;
         if (ena_xor_up_o) begin
            if (n_xfer < 8) begin xfer_cyc[n_xfer] = c; xfer_rnd[n_xfer] = int'(round_o); end
            if (!ena_reg_state_o) up_err++;
            n_xfer++;
            wait_cnt = 0;
         end
         if (cipher_valid_o) begin n_cipher++; cipher_cyc = c; cipher_rnd = int'(round_o); end
         if (ena_xor_down_o) begin
            case (xor_down_sel_o)
               3'd1: begin n_sel1++; sel1_cyc = c; end
               3'd2: n_sel2++;
               3'd3: begin n_sel3++; sel3_cipher = n_cipher; end
               3'd4: begin n_sel4++; sel4_cyc = c; end
               default: ;
            endcase
         end
         if (tag_valid_o) begin tag_cyc = c; done = 1; end
      end
      start_i = 1'b0;
      blk_valid_i = 1'b0;
      check("tag_seen", int'(done), 1);
      @(negedge clock_i); #1;
      check("idle_after_done", int'(busy_o), 0);
      check("tag_one_cycle", int'(tag_valid_o), 0);
   endtask

   task automatic check_single(input string pfx);
      check({pfx, "_select_cnt"}, n_select, 1);
      check({pfx, "_select_cyc"}, select_cyc, 1);
      check({pfx, "_init_rounds"}, rnd_err, 0);
      check({pfx, "_first_ready"}, first_ready, 13);
      check({pfx, "_xfers"}, n_xfer, 2);
      check({pfx, "_ad_xfer_cyc"}, xfer_cyc[0], 13);
      check({pfx, "_ad_xfer_rnd"}, xfer_rnd[0], 6);
      check({pfx, "_sel4_cyc"}, sel4_cyc, 18);
      check({pfx, "_pt_xfer_cyc"}, xfer_cyc[1], 19);
      check({pfx, "_cipher_cyc"}, cipher_cyc, 19);
      check({pfx, "_cipher_rnd"}, cipher_rnd, 0);
      check({pfx, "_sel1_cnt"}, n_sel1, 2);
      check({pfx, "_sel1_last"}, sel1_cyc, 30);
      check({pfx, "_tag_cyc"}, tag_cyc, 31);
      check({pfx, "_up_with_reg"}, up_err, 0);
   endtask

   initial begin
      #1;
      check("rst_busy", int'(busy_o), 0);
      check("rst_ready", int'(blk_ready_o), 0);
      check("rst_round", int'(round_o), 0);
      check("rst_regen", int'(ena_reg_state_o), 0);
      repeat (2) @(negedge clock_i);
      resetb_i = 1'b1;

      // Reset while in PERM_AD, then a normal run
      @(negedge clock_i);
      nb_ad_i = 8'd1; nb_pt_i = 8'd1; start_i = 1'b1; blk_valid_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
      repeat (14) @(negedge clock_i);
      #1;
      check("pre_rst_busy", int'(busy_o), 1);
      resetb_i = 1'b0;
      #1;
      check("midrst_busy", int'(busy_o), 0);
      check("midrst_round", int'(round_o), 0);
      check("midrst_regen", int'(ena_reg_state_o), 0);
      check("midrst_up", int'(ena_xor_up_o), 0);
      check("midrst_down", int'(ena_xor_down_o), 0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      blk_valid_i = 1'b0;

      run_enc(8'd1, 8'd1, -1, -1, -1);
      check_single("t1");

      run_enc(8'd0, 8'd0, -1, -1, -1);
      check_single("t0");

      run_enc(8'd2, 8'd3, 3, -1, -1);
      check("t23_xfers", n_xfer, 5);
      check("t23_cipher", n_cipher, 3);
      check("t23_sel2", n_sel2, 1);
      check("t23_sel3", n_sel3, 1);
      check("t23_sel3_blk", sel3_cipher, 2);
      check("t23_sel1", n_sel1, 2);
      check("t23_sel4", n_sel4, 0);
      check("t23_up_with_reg", up_err, 0);

      // start_i pulses in INIT (cycle 5) and PERM_PT (cycle 21) are ignored
      run_enc(8'd1, 8'd2, -1, 5, 21);
      check("tg_xfers", n_xfer, 3);
      check("tg_last_xfer", xfer_cyc[2], 25);
      check("tg_sel3", n_sel3, 1);
      check("tg_sel1_last", sel1_cyc, 36);
      check("tg_tag_cyc", tag_cyc, 37);

`ifdef ASCON_CTRL_ABORT_EN
      begin
         int tags = 0;
         @(negedge clock_i);
         nb_ad_i = 8'd1; nb_pt_i = 8'd1; start_i = 1'b1; blk_valid_i = 1'b1;
         for (int c = 1; c <= 19; c++) begin
            @(negedge clock_i);
            start_i = 1'b0;
            abort_i = (c == 19);
         end
         #1;
         check("ab_ready_before", int'(blk_ready_o), 1);
         check("ab_no_up", int'(ena_xor_up_o), 0);
         check("ab_no_cipher", int'(cipher_valid_o), 0);
         @(negedge clock_i);
         abort_i = 1'b0;
         #1;
         check("ab_busy", int'(busy_o), 0);
         check("ab_ready", int'(blk_ready_o), 0);
         for (int c = 0; c < 20; c++) begin
            @(negedge clock_i); #1;
            if (tag_valid_o) tags++;
         end
         check("ab_no_tag", tags, 0);
         blk_valid_i = 1'b0;
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
